// File: rtl/dsp48a1_slice_pkg.sv
// rtl/dsp48a1_slice_pkg.sv - shared widths, OPMODE field positions and X/Z mux encodings
package dsp48a1_slice_pkg;

    localparam int AB_W  = 18;   // A, B, D, BCIN, BCOUT and pre-adder width
    localparam int M_W   = 36;   // multiplier product width
    localparam int P_W   = 48;   // C, PCIN, P, PCOUT and post-adder width
    localparam int OPM_W = 8;    // OPMODE width
    localparam int DX_W  = P_W - 2 * AB_W;  // D bits used by the concatenated X operand

    // OPMODE field bit positions
    localparam int OPM_X_LSB      = 0;  // [1:0] X mux select
    localparam int OPM_Z_LSB      = 2;  // [3:2] Z mux select
    localparam int OPM_PREADD_EN  = 4;  // 1: pre-adder result feeds B1, 0: B0 passes through
    localparam int OPM_CARRY      = 5;  // carry-in source when CARRYINSEL is "OPMODE5"
    localparam int OPM_PRESUB     = 6;  // 1: D - B0, 0: D + B0
    localparam int OPM_POSTSUB    = 7;  // 1: Z - (X + CYI), 0: Z + X + CYI

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

endpackage

// File: rtl/dsp48a1_slice_if.sv
// rtl/dsp48a1_slice_if.sv - operand, control and result bundle of the DSP slice
//
// master: drives operands (a, b, d, bcin, c, pcin), opmode, carryin and the
//         per-stage clock enables; receives bcout, m, p, pcout, carryout(f).
// slave : the slice itself.
interface dsp48a1_slice_if;
    import dsp48a1_slice_pkg::*;

    logic [AB_W-1:0]  a;
    logic [AB_W-1:0]  b;
    logic [AB_W-1:0]  d;
    logic [AB_W-1:0]  bcin;
    logic [P_W-1:0]   c;
    logic [P_W-1:0]   pcin;
    logic [OPM_W-1:0] opmode;
    logic             carryin;

    logic             cea;
    logic             ceb;
    logic             cec;
    logic             ced;
    logic             cem;
    logic             cep;
    logic             cecarryin;
    logic             ceopmode;

    logic [AB_W-1:0]  bcout;
    logic [M_W-1:0]   m;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   pcout;
    logic             carryout;
    logic             carryoutf;

    modport master (
        output a, b, d, bcin, c, pcin, opmode, carryin,
        output cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode,
        input  bcout, m, p, pcout, carryout, carryoutf
    );

    modport slave (
        input  a, b, d, bcin, c, pcin, opmode, carryin,
        input  cea, ceb, cec, ced, cem, cep, cecarryin, ceopmode,
        output bcout, m, p, pcout, carryout, carryoutf
    );

endinterface

// File: rtl/dsp_pipe_stage.sv
// rtl/dsp_pipe_stage.sv - optional pipeline register with clock enable and async active-low reset
//
// Ports: clk, rst_n (async, active low), ce (load enable), d (in), q (out).
// ENABLE=0 turns the stage into a plain wire; clk/ce/rst_n are then ignored.
module dsp_pipe_stage #(
    parameter int WIDTH  = 1,
    parameter int ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (ENABLE != 0) begin : g_reg
            logic [WIDTH-1:0] q_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_r <= '0;
                end else if (ce) begin
                    q_r <= d;
                end
            end

            assign q = q_r;
        end else begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp48a1_slice.sv
// rtl/dsp48a1_slice.sv - Spartan-6 style DSP slice: pre-adder, 18x18 multiplier, 48-bit post-adder
//
// Ports:
//   clk                         rising-edge clock
//   rsta .. rstopmode           per-stage asynchronous active-low resets
//   bus (dsp48a1_slice_if.slave) operands, opmode, carry-in, clock enables and results
module dsp48a1_slice
    import dsp48a1_slice_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic                 clk,
    input  logic                 rsta,
    input  logic                 rstb,
    input  logic                 rstc,
    input  logic                 rstd,
    input  logic                 rstm,
    input  logic                 rstp,
    input  logic                 rstcarryin,
    input  logic                 rstopmode,
    dsp48a1_slice_if.slave       bus
);

    // Anything other than the exact alternative strings falls back to the default source.
    localparam bit USE_BCIN      = (B_INPUT == "CASCADE");
    localparam bit USE_CARRYIN_PORT = (CARRYINSEL == "CARRYIN");

    logic [AB_W-1:0]  b_src;
    logic [AB_W-1:0]  b0_q;
    logic [AB_W-1:0]  a0_q;
    logic [AB_W-1:0]  a1_q;
    logic [AB_W-1:0]  d_q;
    logic [P_W-1:0]   c_q;
    logic [OPM_W-1:0] opm_q;
    logic [AB_W-1:0]  preadd;
    logic [AB_W-1:0]  b1_q;
    logic [M_W-1:0]   product;
    logic [M_W-1:0]   m_q;
    logic             cyi_src;
    logic             cyi_q;
    logic [P_W-1:0]   x_mux;
    logic [P_W-1:0]   z_mux;
    logic [P_W:0]     post_sum;
    logic [P_W-1:0]   p_q;
    logic             co_q;

    assign b_src = USE_BCIN ? bus.bcin : bus.b;

    // Input stages
    dsp_pipe_stage #(.WIDTH(AB_W), .ENABLE(B0REG)) u_b0 (
        .clk(clk), .rst_n(rstb), .ce(bus.ceb), .d(b_src), .q(b0_q)
    );

    dsp_pipe_stage #(.WIDTH(AB_W), .ENABLE(A0REG)) u_a0 (
        .clk(clk), .rst_n(rsta), .ce(bus.cea), .d(bus.a), .q(a0_q)
    );

    dsp_pipe_stage #(.WIDTH(AB_W), .ENABLE(A1REG)) u_a1 (
        .clk(clk), .rst_n(rsta), .ce(bus.cea), .d(a0_q), .q(a1_q)
    );

    dsp_pipe_stage #(.WIDTH(AB_W), .ENABLE(DREG)) u_d (
        .clk(clk), .rst_n(rstd), .ce(bus.ced), .d(bus.d), .q(d_q)
    );

    dsp_pipe_stage #(.WIDTH(P_W), .ENABLE(CREG)) u_c (
        .clk(clk), .rst_n(rstc), .ce(bus.cec), .d(bus.c), .q(c_q)
    );

    dsp_pipe_stage #(.WIDTH(OPM_W), .ENABLE(OPMODEREG)) u_opm (
        .clk(clk), .rst_n(rstopmode), .ce(bus.ceopmode), .d(bus.opmode), .q(opm_q)
    );

    // Pre-adder: wraps modulo 2^18, same as the hardware.
    always_comb begin
        preadd = b0_q;
        if (opm_q[OPM_PREADD_EN]) begin
            if (opm_q[OPM_PRESUB]) begin
                preadd = d_q - b0_q;
            end else begin
                preadd = d_q + b0_q;
            end
        end
    end

    dsp_pipe_stage #(.WIDTH(AB_W), .ENABLE(B1REG)) u_b1 (
        .clk(clk), .rst_n(rstb), .ce(bus.ceb), .d(preadd), .q(b1_q)
    );

    assign bus.bcout = b1_q;

    // Unsigned 18x18 multiply; operands zero-extended so the product keeps all 36 bits.
    assign product = {{(M_W-AB_W){1'b0}}, a1_q} * {{(M_W-AB_W){1'b0}}, b1_q};

    dsp_pipe_stage #(.WIDTH(M_W), .ENABLE(MREG)) u_m (
        .clk(clk), .rst_n(rstm), .ce(bus.cem), .d(product), .q(m_q)
    );

    assign bus.m = m_q;

    // Carry-in source, then its optional register.
    assign cyi_src = USE_CARRYIN_PORT ? bus.carryin : opm_q[OPM_CARRY];

    dsp_pipe_stage #(.WIDTH(1), .ENABLE(CARRYINREG)) u_cyi (
        .clk(clk), .rst_n(rstcarryin), .ce(bus.cecarryin), .d(cyi_src), .q(cyi_q)
    );

    // X operand select
    always_comb begin
        x_mux = '0;
        case (x_sel_e'(opm_q[OPM_X_LSB +: 2]))
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_q};
            X_P:     x_mux = p_q;
            X_DAB:   x_mux = {d_q[DX_W-1:0], a1_q, b1_q};
            default: x_mux = '0;
        endcase
    end

    // Z operand select
    always_comb begin
        z_mux = '0;
        case (z_sel_e'(opm_q[OPM_Z_LSB +: 2]))
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = bus.pcin;
            Z_P:     z_mux = p_q;
            Z_C:     z_mux = c_q;
            default: z_mux = '0;
        endcase
    end

    // 49-bit post-adder; in subtract mode bit 48 is the borrow of the two's-complement result.
    always_comb begin
        post_sum = '0;
        if (opm_q[OPM_POSTSUB]) begin
            post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cyi_q});
        end else begin
            post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cyi_q};
        end
    end

    dsp_pipe_stage #(.WIDTH(P_W), .ENABLE(PREG)) u_p (
        .clk(clk), .rst_n(rstp), .ce(bus.cep), .d(post_sum[P_W-1:0]), .q(p_q)
    );

    // Carry-out shares the carry-in enable and reset, as on the original primitive.
    dsp_pipe_stage #(.WIDTH(1), .ENABLE(CARRYOUTREG)) u_co (
        .clk(clk), .rst_n(rstcarryin), .ce(bus.cecarryin), .d(post_sum[P_W]), .q(co_q)
    );

    assign bus.p         = p_q;
    assign bus.pcout     = p_q;
    assign bus.carryout  = co_q;
    assign bus.carryoutf = co_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb/tb_dsp48a1_slice.sv - directed self-checking bench for dsp48a1_slice with default parameters
module tb_dsp48a1_slice;

    logic clk;
    logic rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;

    int n_checks = 0;
    int n_fails  = 0;

    dsp48a1_slice_if bus ();

    dsp48a1_slice dut (
        .clk        (clk),
        .rsta       (rsta),
        .rstb       (rstb),
        .rstc       (rstc),
        .rstd       (rstd),
        .rstm       (rstm),
        .rstp       (rstp),
        .rstcarryin (rstcarryin),
        .rstopmode  (rstopmode),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_resets(input logic v);
        rsta = v; rstb = v; rstc = v; rstd = v;
        rstm = v; rstp = v; rstcarryin = v; rstopmode = v;
    endtask

    task automatic apply(input logic [7:0] opm, input logic [17:0] av, input logic [17:0] bv,
                         input logic [17:0] dv, input logic [47:0] cv);
        bus.opmode = opm;
        bus.a      = av;
        bus.b      = bv;
        bus.d      = dv;
        bus.c      = cv;
    endtask

    initial begin
        set_resets(1'b0);
        bus.cea = 1'b1; bus.ceb = 1'b1; bus.cec = 1'b1; bus.ced = 1'b1;
        bus.cem = 1'b1; bus.cep = 1'b1; bus.cecarryin = 1'b1; bus.ceopmode = 1'b1;
        bus.carryin = 1'b1;
        bus.bcin    = 18'h15A5A;
        bus.pcin    = 48'h1234_5678_9ABC;
        apply(8'hB7, 18'h2A5C3, 18'h1F00D, 18'h3C3C3, 48'hDEAD_BEEF_0123);

        // All stages held in reset with arbitrary inputs
        repeat (3) tick();
        check("rst_p",         48'(bus.p),         48'h0);
        check("rst_pcout",     48'(bus.pcout),     48'h0);
        check("rst_m",         48'(bus.m),         48'h0);
        check("rst_bcout",     48'(bus.bcout),     48'h0);
        check("rst_carryout",  48'(bus.carryout),  48'h0);
        check("rst_carryoutf", 48'(bus.carryoutf), 48'h0);

        // First edge after release: P/M/carry still built from cleared stages
        set_resets(1'b1);
        tick();
        check("rel_p",        48'(bus.p),        48'h0);
        check("rel_m",        48'(bus.m),        48'h0);
        check("rel_carryout", 48'(bus.carryout), 48'h0);

        // (D+B)*A + C
        bus.carryin = 1'b0;
        bus.pcin    = 48'h0;
        apply(8'h1D, 18'd2, 18'd3, 18'd4, 48'd10);
        repeat (5) tick();
        check("add_m",         48'(bus.m),         48'd14);
        check("add_p",         48'(bus.p),         48'd24);
        check("add_pcout",     48'(bus.pcout),     48'd24);
        check("add_bcout",     48'(bus.bcout),     48'd7);
        check("add_carryout",  48'(bus.carryout),  48'd0);
        check("add_carryoutf", 48'(bus.carryoutf), 48'd0);

        // Reset only the P stage mid-operation; M keeps its value, P refills
        rstp = 1'b0;
        #1;
        check("rstp_p", 48'(bus.p), 48'd0);
        check("rstp_m", 48'(bus.m), 48'd14);
        rstp = 1'b1;
        tick();
        check("rstp_refill_p", 48'(bus.p), 48'd24);

        // (D-B)*A + C
        apply(8'h5D, 18'd5, 18'd3, 18'd10, 48'd1);
        repeat (5) tick();
        check("presub_m",     48'(bus.m),     48'd35);
        check("presub_p",     48'(bus.p),     48'd36);
        check("presub_bcout", 48'(bus.bcout), 48'd7);

        // C - (D+B)*A
        apply(8'h9D, 18'd2, 18'd1, 18'd2, 48'd100);
        repeat (5) tick();
        check("postsub_m",        48'(bus.m),        48'd6);
        check("postsub_p",        48'(bus.p),        48'd94);
        check("postsub_carryout", 48'(bus.carryout), 48'd0);

        // X = {D[11:0], A, B}, Z = 0
        apply(8'h03, 18'h00002, 18'h00003, 18'h001, 48'd100);
        repeat (5) tick();
        check("concat_p",     48'(bus.p),     48'h0010_0008_0003);
        check("concat_m",     48'(bus.m),     48'd6);
        check("concat_bcout", 48'(bus.bcout), 48'd3);

        // All-ones concat + C=1 wraps to 0 with carry out
        apply(8'h0F, 18'h3FFFF, 18'h3FFFF, 18'hFFF, 48'd1);
        repeat (5) tick();
        check("wrap_p",         48'(bus.p),         48'h0);
        check("wrap_carryout",  48'(bus.carryout),  48'd1);
        check("wrap_carryoutf", 48'(bus.carryoutf), 48'd1);
        check("wrap_m",         48'(bus.m),         48'h0_000F_FFF8_0001);

        // Prime M=1 while the concat path gives a known P
        apply(8'h0F, 18'd1, 18'd1, 18'd0, 48'd0);
        repeat (5) tick();
        check("prime_p",        48'(bus.p),        48'h0000_0004_0001);
        check("prime_m",        48'(bus.m),        48'd1);
        check("prime_carryout", 48'(bus.carryout), 48'd0);

        // Accumulate P += M; the OPMODE register adds one cycle before it takes effect
        bus.opmode = 8'h09;
        tick();
        check("acc_opm_delay_p", 48'(bus.p), 48'h0000_0004_0001);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("acc_p_%0d", i), 48'(bus.p), 48'h0000_0004_0001 + 48'(i));
        end

        // Drop CEP: P freezes although the adder keeps producing P+1
        bus.cep = 1'b0;
        repeat (3) tick();
        check("freeze_p",     48'(bus.p),     48'h0000_0004_0004);
        check("freeze_pcout", 48'(bus.pcout), 48'h0000_0004_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dsp48a1_slice.md
Name: dsp48a1_slice

Overview:
- Parameterisable DSP slice modelled on the Xilinx Spartan-6 DSP48A1.
- Datapath: 18-bit pre-adder/subtracter (D±B), 18x18 unsigned multiplier, 48-bit post-adder/subtracter with X/Z operand muxes and carry logic.
- Every pipeline stage is individually optional (parameter), clock-enabled and resettable.
- Used as the arithmetic leaf in filter/MAC datapaths; cascades via BCIN/BCOUT and PCIN/PCOUT.

Parameters:
- A0REG, 0: first A pipeline stage present (1) or bypassed (0).
- A1REG, 1: second A stage.
- B0REG, 0: first B stage.
- B1REG, 1: second B stage (after pre-adder).
- CREG, 1: C input register.
- DREG, 1: D input register.
- MREG, 1: multiplier output register.
- PREG, 1: P output register.
- CARRYINREG, 1: carry-in register.
- CARRYOUTREG, 1: carry-out register.
- OPMODEREG, 1: OPMODE register.
- CARRYINSEL, "OPMODE5": "OPMODE5" selects OPMODE[5] as carry-in; "CARRYIN" selects the port; any other value behaves as "OPMODE5".
- B_INPUT, "DIRECT": "DIRECT" selects B, "CASCADE" selects BCIN; any other value behaves as "DIRECT".

Ports:
- CLK  in  1  single clock, rising edge.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE  in  1 each  per-stage asynchronous active-low resets.
- A, B, D, BCIN  in  18  operands / B cascade in.
- C, PCIN  in  48  post-adder operand / P cascade in.
- OPMODE  in  8  operation select.
- CARRYIN  in  1  external carry-in.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE  in  1 each  per-stage clock enables.
- BCOUT  out  18  B1 stage output.
- M  out  36  multiplier stage output.
- P, PCOUT  out  48  result; PCOUT identical to P.
- CARRYOUT, CARRYOUTF  out  1  post-adder carry; both carry the same value.

Behaviour:
- Registered stage: clears to 0 asynchronously while its RST is low; otherwise loads on a CLK rise when its CE is 1, else holds.
- Bypassed stage (param 0): pure wire; its CE/RST have no effect.
- Reset value of every output is 0 (once the driving registers are reset).
- Stage order: B source mux (B_INPUT) → B0 stage; A → A0 stage; D → DREG; C → CREG; OPMODE → OPMODEREG. All downstream OPMODE uses take the registered/bypassed value.
- Pre-adder:
  - OPMODE[4]=0: passes B0.
  - OPMODE[4]=1, OPMODE[6]=0: D+B0.
  - OPMODE[4]=1, OPMODE[6]=1: D−B0.
  - Result is 18 bits, modulo 2^18.
  - Feeds the B1 stage; BCOUT = B1 stage output.
- A0 output feeds the A1 stage.
- Multiplier: A1 × B1 unsigned, 36 bits → MREG stage → M.
- X mux (OPMODE[1:0]):
  - 0 → 0.
  - 1 → M zero-extended to 48.
  - 2 → P.
  - 3 → {D_stage[11:0], A1[17:0], B1[17:0]}.
- Z mux (OPMODE[3:2]):
  - 0 → 0.
  - 1 → PCIN.
  - 2 → P.
  - 3 → C stage.
- Carry-in: chosen per CARRYINSEL, passed through the CARRYINREG stage (CYI).
- Post-adder (49-bit arithmetic, result modulo 2^48, bit 48 = carry):
  - OPMODE[7]=0: Z + X + CYI.
  - OPMODE[7]=1: Z − (X + CYI); bit 48 is the borrow, taken from the 49-bit two's-complement result.
- Post-adder bits 47:0 → PREG stage → P/PCOUT; bit 48 → CARRYOUTREG stage → CARRYOUT/CARRYOUTF.
- Selecting P in X or Z with PREG=0 is a combinational loop and is unsupported; benches must not do it.
- Latency with default parameters, inputs held, all CE=1:
  - A→P: 3 cycles.
  - D (with pre-adder) → P: 4 cycles.
  - C→P: 2 cycles.
  - OPMODE change: 1 extra cycle.
- Reset mid-operation clears only the stage reset; other stages keep their values and the pipeline refills normally.
- All CE low: every registered output holds indefinitely.

Decomposition:
- Shared package: OPMODE field bit positions, X/Z select encodings, width constants (18, 36, 48).
- One natural sub-module: dsp_pipe_stage. Parameters are WIDTH and ENABLE. Inputs are d, ce, rst_n, clk; output is q. It is instantiated for every optional stage.

Test Plan:
1. All RSTx low, random inputs → P=0, PCOUT=0, M=0, BCOUT=0, CARRYOUT=0; release resets → outputs stay 0 until operands propagate.
2. OPMODE=0x1D, A=2, B=3, D=4, C=10, held 5 cycles → M=14, P=24, CARRYOUT=0.
3. OPMODE=0x5D, A=5, B=3, D=10, C=1 → M=35, P=36.
4. OPMODE=0x9D, A=2, B=1, D=2, C=100 → M=6, P=94.
5. OPMODE=0x03, D=0x001, A=0x00002, B=0x00003 → P=0x0010_0008_0003.
6. Carry and accumulate:
   - OPMODE=0x0F, D=0xFFF, A=0x3FFFF, B=0x3FFFF, C=1 → P=0, CARRYOUT=CARRYOUTF=1.
   - Then OPMODE=0x09, A=1, B=1, D=0 → P increments by 1 per cycle.
   - Then drop CEP → P frozen.
